iomem_arbiter: RTL
==================

# iomem_arbiter

Two-requester arbiter for the PicoSoC iomem bus. Shares one downstream iomem slave port (the GPIO/LED register block at 0x03xx_xxxx and any later peripherals) between the CPU's iomem port (m0) and a second bus master (m1, e.g. a debug or DMA engine). Grants are round-robin and hold for a whole transaction. An optional watchdog terminates transactions the slave never acknowledges.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: busy cycles without s_ready before forced completion; legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the watchdog counter.

Ports:
- clk  in  1  system clock; the only clock.
- resetn  in  1  asynchronous, active-low reset.
- m0_valid / m1_valid  in  1  request, held until the matching ready.
- m0_wstrb / m1_wstrb  in  4  byte write strobes; 0 = read.
- m0_addr / m1_addr  in  32  byte address.
- m0_wdata / m1_wdata  in  32  write data.
- m0_ready / m1_ready  out  1  one-cycle completion pulse.
- m0_rdata / m1_rdata  out  32  read data, valid while the matching ready is high.
- s_valid  out  1  forwarded request.
- s_wstrb  out  4  forwarded strobes.
- s_addr  out  32  forwarded address.
- s_wdata  out  32  forwarded write data.
- s_ready  in  1  slave completion pulse.
- s_rdata  in  32  slave read data.
- grant  out  2  one-hot owner; 00 when idle.
- timeout_err  out  1  sticky watchdog flag.

## Operation
- FSM states: IDLE, BUSY0, BUSY1. Reset state is IDLE, with rr_ptr=0 (m0 preferred), grant=00 and timeout_err=0.
- IDLE:
  - One requester valid: go to BUSYn for that requester.
  - Both valid: go to BUSY(rr_ptr).
  - In IDLE, s_valid=0 and both m*_ready=0.
- BUSYn:
  - s_valid, s_wstrb, s_addr and s_wdata are combinationally muxed from master n.
  - m(n)_ready = s_ready and m(n)_rdata = s_rdata, both combinationally.
  - The non-granted master sees ready=0 and rdata=0.
- Completion: s_ready high in BUSYn → next state IDLE, rr_ptr = the other master.
- Protocol violation: if the granted master drops valid in BUSYn before s_ready, the FSM returns to IDLE the next cycle. rr_ptr is unchanged and no ready is issued.
- Slave contract: s_ready is ignored while s_valid=0.
- Unused outputs: while idle, s_* outputs are driven to 0.
- No back-to-back grants: every transaction passes through at least one IDLE cycle.
- Reset mid-transaction: all state clears immediately. s_valid drops asynchronously and no ready is issued.

## Timing
- Arbitration latency: 1 cycle. Valid seen in IDLE at edge k; s_valid asserted in cycle k+1.
- Data path: zero added latency from s_ready to m_ready, because ready and rdata pass through combinationally.
- Minimum transaction length: 2 cycles (IDLE + BUSY with s_ready in the first BUSY cycle).
- Throughput: one transaction per 2 cycles at best; masters alternate under contention.
- grant is registered and equals the state encoding.

## Configuration
- With IOMEM_ARB_TIMEOUT_EN defined:
  - A CNT_W-bit counter clears on entering BUSYn and increments each BUSY cycle without s_ready.
  - When the count reaches TIMEOUT_CYCLES, the arbiter asserts m(n)_ready for one cycle with m(n)_rdata = 32'hFFFF_FFFF and forces s_valid=0 in that cycle.
  - It then sets timeout_err, advances rr_ptr and goes to IDLE.
  - If s_ready and the timeout coincide, s_ready wins: normal completion, no error.
  - timeout_err clears only on reset.
- Without the macro: no counter is built, timeout_err is tied to 0, and a hung slave stalls the bus indefinitely.

## Structure
- Package iomem_arb_pkg holds:
  - the state encoding (IDLE=2'b00, BUSY0=2'b01, BUSY1=2'b10, which doubles as grant);
  - the timeout read value 32'hFFFF_FFFF;
  - the default TIMEOUT_CYCLES.
- One sub-module: iomem_arb_wdog, holding the counter and the expiry compare, instantiated only under IOMEM_ARB_TIMEOUT_EN.

## Test plan
- m0 write only: addr 0x0300_0000, wdata 0x0000_00A5, wstrb 4'hF.
  - s_valid is asserted one cycle after m0_valid, with s_addr=0x0300_0000.
  - Slave acks after 3 cycles → m0_ready pulses in the same cycle; grant returns to 00.
- Both masters valid from reset, continuously, with a slave acking each request after 1 cycle:
  - grant sequence is 01, 00, 10, 00, 01.
  - Each master completes every other transaction.
- m1 read, slave returns s_rdata=0x1234_5678 → m1_rdata=0x1234_5678 while m1_ready=1; m0_rdata=0.
- Timeout with macro, TIMEOUT_CYCLES=4, slave never acks:
  - m0_ready pulses with rdata 0xFFFF_FFFF after 4 BUSY cycles;
  - timeout_err=1 and stays 1;
  - the next m1 request is then granted.
- Timeout race: s_ready arrives exactly in the expiry cycle → normal completion with slave data; timeout_err stays 0.
- Reset abort: resetn deasserted mid-BUSY1 → s_valid, grant and timeout_err are 0 immediately; after release, m0 is served first.

Source files
------------

// File: rtl/iomem_arb_pkg.sv
// Shared state encoding and constants for the two-master iomem arbiter.
// The state encoding is also the one-hot grant presented to the outside world.
package iomem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY0 = 2'b01,
        BUSY1 = 2'b10
    } arbState_t;

    localparam logic [31:0] TIMEOUT_RDATA          = 32'hFFFF_FFFF;
    localparam int          DEFAULT_TIMEOUT_CYCLES = 255;
    localparam int          DEFAULT_CNT_W          = 8;

endpackage

// File: rtl/iomem_arb_wdog.sv
// Watchdog for the iomem arbiter: counts busy cycles without a slave ack and flags expiry.
// Only instantiated when IOMEM_ARB_TIMEOUT_EN is defined.
module iomem_arb_wdog
    import iomem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_busy,
    input  logic i_ack,
    output logic o_expire
);

    logic [CNT_W-1:0] r_count;

    // Idle cycles clear the count, so every grant starts from zero; it holds once expired.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (!i_busy) begin
            r_count <= '0;
        end else if (!i_ack && !o_expire) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = i_busy && (r_count == CNT_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/iomem_arbiter.sv
// Round-robin arbiter sharing one iomem slave port between two masters.
// Define IOMEM_ARB_TIMEOUT_EN to build the watchdog that terminates unacknowledged transactions.
module iomem_arbiter
    import iomem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEFAULT_CNT_W
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic [1:0]  grant,
    output logic        timeout_err
);

    arbState_t r_state;
    arbState_t w_nextState;
    logic      r_rrPtr;
    logic      w_rrPtrNext;
    logic      w_busy;
    logic      w_grantValid;
    logic      w_ack;
    logic      w_timeout;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_rrPtr <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_rrPtr <= w_rrPtrNext;
        end
    end

    assign w_busy = (r_state != IDLE);

    always_comb begin
        w_grantValid = 1'b0;
        case (r_state)
            BUSY0:   w_grantValid = m0_valid;
            BUSY1:   w_grantValid = m1_valid;
            default: w_grantValid = 1'b0;
        endcase
    end

    // A slave ack only counts while the owner still presents its request.
    assign w_ack = w_grantValid & s_ready;

`ifdef IOMEM_ARB_TIMEOUT_EN
    logic w_expire;
    logic r_timeoutErr;

    iomem_arb_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_wdog (
        .clk      (clk),
        .resetn   (resetn),
        .i_busy   (w_busy),
        .i_ack    (s_ready),
        .o_expire (w_expire)
    );

    // A real ack in the expiry cycle wins, so the timeout never masks slave data.
    assign w_timeout = w_expire & w_grantValid & ~s_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_timeoutErr <= 1'b0;
        end else if (w_timeout) begin
            r_timeoutErr <= 1'b1;
        end
    end

    assign timeout_err = r_timeoutErr;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        w_nextState = r_state;
        w_rrPtrNext = r_rrPtr;
        case (r_state)
            IDLE: begin
                if (m0_valid && m1_valid) begin
                    w_nextState = r_rrPtr ? BUSY1 : BUSY0;
                end else if (m0_valid) begin
                    w_nextState = BUSY0;
                end else if (m1_valid) begin
                    w_nextState = BUSY1;
                end
            end
            BUSY0, BUSY1: begin
                // An abandoned request leaves the round-robin pointer untouched.
                if (!w_grantValid) begin
                    w_nextState = IDLE;
                end else if (w_ack || w_timeout) begin
                    w_nextState = IDLE;
                    w_rrPtrNext = (r_state == BUSY0);
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        s_valid  = 1'b0;
        s_wstrb  = '0;
        s_addr   = '0;
        s_wdata  = '0;
        m0_ready = 1'b0;
        m0_rdata = '0;
        m1_ready = 1'b0;
        m1_rdata = '0;
        case (r_state)
            BUSY0: begin
                s_valid  = m0_valid & ~w_timeout;
                s_wstrb  = m0_wstrb;
                s_addr   = m0_addr;
                s_wdata  = m0_wdata;
                m0_ready = w_ack | w_timeout;
                m0_rdata = w_timeout ? TIMEOUT_RDATA : s_rdata;
            end
            BUSY1: begin
                s_valid  = m1_valid & ~w_timeout;
                s_wstrb  = m1_wstrb;
                s_addr   = m1_addr;
                s_wdata  = m1_wdata;
                m1_ready = w_ack | w_timeout;
                m1_rdata = w_timeout ? TIMEOUT_RDATA : s_rdata;
            end
            default: ;
        endcase
    end

    assign grant = r_state;

endmodule
